stream_pacer: RTL and testbench
===============================

Name: stream_pacer

Overview:
- Upstream feeder for the fixed-latency 8-bit register delay line.
- The delay line samples `data_in` every clock and has no valid or stall signal, so it must be fed one byte per cycle without gaps.
- This block accepts bursty valid/ready traffic into a small FIFO and primes the FIFO to a start level before streaming.
- It drives exactly one byte per cycle, substituting a fill byte and flagging non-live cycles, and counts underruns.

Parameters:
- DATA_W, 8, width of data bytes (matches delay line).
- FIFO_DEPTH, 8, FIFO entries; power of two, ≥2.
- START_LEVEL, 4, occupancy required before streaming begins; legal range 1..FIFO_DEPTH.
- FILL_BYTE, 8'h00, value driven on out_data when no live byte is available.
- CNT_W, 16, width of the underrun counter.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst_n, input, 1: reset; synchronous, active-low.
- in_valid, input, 1: upstream byte valid.
- in_data, input, DATA_W: upstream byte.
- in_ready, output, 1: block can accept a byte this cycle.
- out_data, output, DATA_W: byte to the delay line data_in; registered.
- out_live, output, 1: out_data carries a real FIFO byte, not fill; registered.
- stream_active, output, 1: FSM is in STREAM.
- underrun_cnt, output, CNT_W: saturating count of underrun events.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - FIFO pointers and occupancy cleared; contents discarded.
  - State IDLE, out_data=FILL_BYTE, out_live=0, underrun_cnt=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-stream obeys the same rule; no byte in flight survives.
- Push:
  - A handshake occurs when in_valid && in_ready at a rising edge.
  - in_ready = (count != FIFO_DEPTH), based on registered occupancy only.
  - No same-cycle pass-through when full, even if a pop occurs that cycle.
- Occupancy:
  - count is updated with +push −pop in the same edge.
  - Simultaneous push and pop leaves count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- FSM states:
  - IDLE: out_data<=FILL_BYTE, out_live<=0. If registered count ≥ START_LEVEL, go to STREAM; no pop occurs in IDLE.
  - STREAM, count≠0: pop the head entry; out_data<=head, out_live<=1; stay in STREAM.
  - STREAM, count==0 (underrun): out_data<=FILL_BYTE, out_live<=0; underrun_cnt<=underrun_cnt+1, saturating at all-ones; go to IDLE and re-prime.
- Latency and cycle counting:
  - If the push that makes count reach START_LEVEL handshakes at edge E:
    - state=STREAM after E+1;
    - first pop occurs at E+2, so out_live=1 with that byte after E+2.
  - Thereafter, one byte per cycle in FIFO order while data is present.
  - A push in the same cycle the FIFO reads empty does not prevent that cycle's underrun.
- stream_active = (state==STREAM), combinational from the state register.
- out_data never goes X: it always carries either a FIFO byte or FILL_BYTE.
- Flow properties:
  - Byte order is preserved.
  - No byte is duplicated or dropped except on reset.

Test Plan:
1. Reset check: hold rst_n=0 for 3 cycles, then release.
   - Required: out_data=8'h00, out_live=0, in_ready=1, stream_active=0, underrun_cnt=0.
   - Data presented during reset is never accepted.
2. Prime and stream (defaults): push A0,A1,A2,A3 on consecutive edges E0..E3, then stop.
   - stream_active=1 after E4.
   - out_live=1 with out_data=A0,A1,A2,A3 after edges E5..E8.
   - After E9: out_data=00, out_live=0, underrun_cnt=1, state IDLE.
3. Full/backpressure (START_LEVEL=8): hold in_valid=1 with bytes 10..18.
   - in_ready drops after the 8th handshake; byte 18 is held.
   - Streaming then emits 10..17 in order.
   - 18 is accepted on the first cycle after the first pop.
4. Continuous steady state: after priming, push one byte per cycle for 100 cycles.
   - out_live stays 1 continuously.
   - Output sequence equals input sequence.
   - count is constant; underrun_cnt=0.
5. Reset mid-stream: assert rst_n=0 for 1 cycle while 3 bytes are queued in STREAM.
   - Next cycle: out_live=0, count=0, state IDLE, underrun_cnt=0.
   - Queued bytes are never emitted.
6. Saturation (CNT_W=2, START_LEVEL=1): repeat push-one-then-starve 5 times.
   - underrun_cnt reads 1,2,3,3,3 and does not wrap.

Source files
------------

// File: rtl/stream_pacer.sv
// stream_pacer: primes a small FIFO and then feeds a gapless delay line with one byte per cycle
module stream_pacer #(
    parameter int                DATA_W      = 8,
    parameter int                FIFO_DEPTH  = 8,
    parameter int                START_LEVEL = 4,
    parameter logic [DATA_W-1:0] FILL_BYTE   = '0,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_live,
    output logic              stream_active,
    output logic [CNT_W-1:0]  underrun_cnt
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic {IDLE, STREAM} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;
    logic              push, pop;

    assign in_ready      = count != (AW+1)'(FIFO_DEPTH);
    assign push          = in_valid && in_ready;
    assign pop           = state == STREAM && count != '0;
    assign stream_active = state == STREAM;

    // Storage needs no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in_data;
    end

    // Pointers and occupancy; pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_ptr + AW'(pop);
            count  <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    // Prime to START_LEVEL, stream until the FIFO runs dry, then count the underrun and re-prime.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            out_data     <= FILL_BYTE;
            out_live     <= 1'b0;
            underrun_cnt <= '0;
        end else if (state == IDLE) begin
            out_data <= FILL_BYTE;
            out_live <= 1'b0;
            state    <= count >= (AW+1)'(START_LEVEL) ? STREAM : IDLE;
        end else if (pop) begin
            out_data <= mem[rd_ptr];
            out_live <= 1'b1;
        end else begin
            out_data     <= FILL_BYTE;
            out_live     <= 1'b0;
            underrun_cnt <= underrun_cnt == '1 ? underrun_cnt : underrun_cnt + 1'b1;
            state        <= IDLE;
        end
    end
endmodule

// File: tb/tb_stream_pacer.sv
// tb_stream_pacer: scoreboard bench for stream_pacer in three parameterisations
module tb_stream_pacer;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic       rst0_n, v0, rdy0, ol0, sa0;
    logic [7:0] d0, od0;
    logic [15:0] uc0;
    logic       rst1_n, v1, rdy1, ol1, sa1;
    logic [7:0] d1, od1;
    logic [15:0] uc1;
    logic       rst2_n, v2, rdy2, ol2, sa2;
    logic [7:0] d2, od2;
    logic [1:0] uc2;

    logic [7:0] q0[$];
    logic [7:0] q1[$];
    logic [7:0] q2[$];

    stream_pacer u0 (.clk(clk), .rst_n(rst0_n), .in_valid(v0), .in_data(d0), .in_ready(rdy0),
                     .out_data(od0), .out_live(ol0), .stream_active(sa0), .underrun_cnt(uc0));
    stream_pacer #(.START_LEVEL(8)) u1 (.clk(clk), .rst_n(rst1_n), .in_valid(v1), .in_data(d1), .in_ready(rdy1),
                     .out_data(od1), .out_live(ol1), .stream_active(sa1), .underrun_cnt(uc1));
    stream_pacer #(.START_LEVEL(1), .CNT_W(2)) u2 (.clk(clk), .rst_n(rst2_n), .in_valid(v2), .in_data(d2), .in_ready(rdy2),
                     .out_data(od2), .out_live(ol2), .stream_active(sa2), .underrun_cnt(uc2));

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Scoreboard: accepted bytes are queued at the handshake edge; reset discards them.
    always @(posedge clk) begin
        if (!rst0_n) q0.delete(); else if (v0 && rdy0) q0.push_back(d0);
        if (!rst1_n) q1.delete(); else if (v1 && rdy1) q1.push_back(d1);
        if (!rst2_n) q2.delete(); else if (v2 && rdy2) q2.push_back(d2);
    end

    // Live bytes must match the queue head; non-live cycles must carry the fill byte.
    always @(negedge clk) begin
        if (ol0 === 1'b1) begin
            chk("u0_expected", 32'(q0.size() > 0), 32'd1);
            if (q0.size() > 0) chk("u0_data", 32'(od0), 32'(q0.pop_front()));
        end else if (ol0 === 1'b0) chk("u0_fill", 32'(od0), 32'h00);
        if (ol1 === 1'b1) begin
            chk("u1_expected", 32'(q1.size() > 0), 32'd1);
            if (q1.size() > 0) chk("u1_data", 32'(od1), 32'(q1.pop_front()));
        end else if (ol1 === 1'b0) chk("u1_fill", 32'(od1), 32'h00);
        if (ol2 === 1'b1) begin
            chk("u2_expected", 32'(q2.size() > 0), 32'd1);
            if (q2.size() > 0) chk("u2_data", 32'(od2), 32'(q2.pop_front()));
        end else if (ol2 === 1'b0) chk("u2_fill", 32'(od2), 32'h00);
    end

    task automatic run0;
        rst0_n = 1'b0;
        v0 = 1'b1;
        d0 = 8'hEE;
        repeat (3) @(negedge clk);
        rst0_n = 1'b1;
        v0 = 1'b0;
        chk("t1_out_data", 32'(od0), 32'h00);
        chk("t1_out_live", 32'(ol0), 32'd0);
        chk("t1_in_ready", 32'(rdy0), 32'd1);
        chk("t1_active", 32'(sa0), 32'd0);
        chk("t1_underrun", 32'(uc0), 32'd0);
        v0 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            d0 = 8'(8'hA0 + i);
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("t2_active_e3", 32'(sa0), 32'd0);
        @(negedge clk);
        chk("t2_active_e4", 32'(sa0), 32'd1);
        chk("t2_live_e4", 32'(ol0), 32'd0);
        repeat (4) @(negedge clk);
        chk("t2_live_e8", 32'(ol0), 32'd1);
        @(negedge clk);
        chk("t2_live_e9", 32'(ol0), 32'd0);
        chk("t2_underrun", 32'(uc0), 32'd1);
        chk("t2_active_e9", 32'(sa0), 32'd0);
        chk("t2_drained", 32'(q0.size()), 32'd0);
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        chk("t4_uc_reset", 32'(uc0), 32'd0);
        v0 = 1'b1;
        for (int i = 0; i < 110; i++) begin
            d0 = 8'(i * 7 + 3);
            @(negedge clk);
            if (i >= 5) chk("t4_live", 32'(ol0), 32'd1);
        end
        chk("t4_underrun", 32'(uc0), 32'd0);
        v0 = 1'b0;
        repeat (2) @(negedge clk);
        chk("t5_active_pre", 32'(sa0), 32'd1);
        chk("t5_live_pre", 32'(ol0), 32'd1);
        rst0_n = 1'b0;
        @(negedge clk);
        rst0_n = 1'b1;
        chk("t5_live", 32'(ol0), 32'd0);
        chk("t5_active", 32'(sa0), 32'd0);
        chk("t5_underrun", 32'(uc0), 32'd0);
        chk("t5_in_ready", 32'(rdy0), 32'd1);
        repeat (10) @(negedge clk);
        chk("t5_still_idle", 32'(sa0), 32'd0);
        chk("t5_no_emit", 32'(ol0), 32'd0);
    endtask

    task automatic run1;
        int w;
        rst1_n = 1'b0;
        v1 = 1'b0;
        d1 = 8'h00;
        repeat (3) @(negedge clk);
        rst1_n = 1'b1;
        v1 = 1'b1;
        for (int b = 0; b < 9; b++) begin
            d1 = 8'(8'h10 + b);
            w = 0;
            if (b == 8) chk("t3_full_ready", 32'(rdy1), 32'd0);
            while (!rdy1 && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (b == 8) chk("t3_wait", 32'(w), 32'd2);
            @(negedge clk);
        end
        v1 = 1'b0;
        chk("t3_live_after_18", 32'(ol1), 32'd1);
        repeat (12) @(negedge clk);
        chk("t3_underrun", 32'(uc1), 32'd1);
        chk("t3_active", 32'(sa1), 32'd0);
        chk("t3_drained", 32'(q1.size()), 32'd0);
    endtask

    task automatic run2;
        rst2_n = 1'b0;
        v2 = 1'b0;
        d2 = 8'h00;
        repeat (3) @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            v2 = 1'b1;
            d2 = 8'(8'h60 + k);
            @(negedge clk);
            v2 = 1'b0;
            repeat (5) @(negedge clk);
            chk("t6_underrun", 32'(uc2), 32'(k < 2 ? k + 1 : 3));
        end
        chk("t6_drained", 32'(q2.size()), 32'd0);
    endtask

    initial begin
        fork
            run0();
            run1();
            run2();
        join
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
